frame_scanout: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/frame_scanout_sig_delay.sv | 25 ++
 rtl/frame_scanout.sv | 119 +++++++++++
 tb/tb_frame_scanout.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// SVGA 800x600@60 timing defaults, framebuffer geometry and pixel colour layout
// shared by the scanout datapath and its bench.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 40;
  localparam int H_SYNC_DEF    = 128;
  localparam int H_BACK_DEF    = 88;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 1;
  localparam int V_SYNC_DEF    = 4;
  localparam int V_BACK_DEF    = 23;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int HS_START_DEF  = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF    = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF  = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF    = VS_START_DEF + V_SYNC_DEF - 1;

  localparam int COLOR_W = 6;
  localparam int CH_W    = 2;
  localparam int R_LSB   = 4;
  localparam int G_LSB   = 2;
  localparam int B_LSB   = 0;

  localparam int FB_W    = 400;
  localparam int FB_H    = 300;
  localparam int ADDR_W  = 9;

endpackage

// File: rtl/frame_scanout_sig_delay.sv
// Plain DEPTH-stage shift register with synchronous clear; DEPTH must be >= 1.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/frame_scanout.sv
// Framebuffer reader: SVGA timing, 2x2 pixel-doubled SRAM reads, colour/sync pins
// aligned READ_LATENCY+2 cycles behind the counters, and SRAM-free signalling.
module frame_scanout
  import vga_timing_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] rd_data,
  output logic [ADDR_W-1:0]  rd_addr_x,
  output logic [ADDR_W-1:0]  rd_addr_y,
  output logic               rd_en,
  output logic [CH_W-1:0]    vga_r,
  output logic [CH_W-1:0]    vga_g,
  output logic [CH_W-1:0]    vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               write_enable,
  output logic               vertical_porch_start
);

  localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START    = H_VISIBLE + H_FRONT;
  localparam int HS_END      = HS_START + H_SYNC - 1;
  localparam int VS_START    = V_VISIBLE + V_FRONT;
  localparam int VS_END      = VS_START + V_SYNC - 1;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        visible;
  logic        hs_raw;
  logic        vs_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 11'(LINE_LEN - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(FRAME_LINES - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign visible = (h_cnt < 11'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
  assign hs_raw  = (h_cnt >= 11'(HS_START)) && (h_cnt <= 11'(HS_END));
  assign vs_raw  = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));

  // Address halving gives the 2x2 doubling; outside the visible area it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_x <= '0;
      rd_addr_y <= '0;
    end else if (visible) begin
      rd_addr_x <= h_cnt[9:1];
      rd_addr_y <= v_cnt[9:1];
    end
  end

  // rd_hist[0] is the read about to be issued, rd_hist[1] is rd_en, the rest are
  // reads still in flight; the SRAM is free only when all of them are clear.
  logic [READ_LATENCY:0] rd_hist;
  assign rd_hist[0] = visible;
  assign rd_en      = rd_hist[1];

  for (genvar k = 0; k < READ_LATENCY; k++) begin : g_rd_hist
    sig_delay #(.WIDTH(1), .DEPTH(1)) u_rd_hist (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_hist[k]),
      .dout (rd_hist[k+1])
    );
  end

  logic vis_d;
  logic hs_d;
  logic vs_d;

  sig_delay #(.WIDTH(3), .DEPTH(READ_LATENCY + 1)) u_sync_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({visible, hs_raw, vs_raw}),
    .dout ({vis_d, hs_d, vs_d})
  );

  logic [COLOR_W-1:0] color;

  always_ff @(posedge clk) begin
    if (rst) begin
      color                <= '0;
      hsync                <= 1'b0;
      vsync                <= 1'b0;
      write_enable         <= 1'b0;
      vertical_porch_start <= 1'b0;
    end else begin
      color                <= vis_d ? rd_data : '0;
      hsync                <= hs_d;
      vsync                <= vs_d;
      write_enable         <= ~(|rd_hist);
      vertical_porch_start <= (h_cnt == 11'd0) && (v_cnt == 10'(V_VISIBLE));
    end
  end

  assign vga_r = color[R_LSB +: CH_W];
  assign vga_g = color[G_LSB +: CH_W];
  assign vga_b = color[B_LSB +: CH_W];

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout with a 1-cycle SRAM model returning rd_addr_x[5:0].
// Vertical timing is shortened to 16 lines so several frames fit in a short run.
module tb_frame_scanout;
  import vga_timing_pkg::*;

  localparam int LINE  = H_TOTAL;
  localparam int VVIS  = 8;
  localparam int FRAME = 16 * LINE;
  localparam int VPS_C = VVIS * LINE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] rd_data = '0;
  logic [8:0] rd_addr_x, rd_addr_y;
  logic rd_en, hsync, vsync, write_enable, vertical_porch_start;
  logic [1:0] vga_r, vga_g, vga_b;
  logic [5:0] rgb;

  assign rgb = {vga_r, vga_g, vga_b};

  frame_scanout #(
    .READ_LATENCY (1),
    .V_VISIBLE    (VVIS),
    .V_FRONT      (1),
    .V_SYNC       (4),
    .V_BACK       (3)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rd_data              (rd_data),
    .rd_addr_x            (rd_addr_x),
    .rd_addr_y            (rd_addr_y),
    .rd_en                (rd_en),
    .vga_r                (vga_r),
    .vga_g                (vga_g),
    .vga_b                (vga_b),
    .hsync                (hsync),
    .vsync                (vsync),
    .write_enable         (write_enable),
    .vertical_porch_start (vertical_porch_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= rd_addr_x[5:0];

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   overlap = 0;
  logic rd_en_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (write_enable && (rd_en || rd_en_q)) overlap++;
    rd_en_q = rd_en;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int nz, we_low, rd_hi, vps_n;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({rd_en, rgb, hsync, vsync, write_enable, vertical_porch_start, rd_addr_x, rd_addr_y}), 0);
    rst = 1'b0;
    cyc = 0;
    check("c0_rd_en", rd_en, 0);
    check("c0_we", write_enable, 0);

    goto(1);
    check("c1_rd_en", rd_en, 1);
    check("c1_addr", {rd_addr_x, rd_addr_y}, 0);
    check("c1_we", write_enable, 0);
    goto(2); check("c2_rgb_blank", rgb, 0);
    goto(5); check("pix2_rgb", rgb, 1);
    goto(6); check("pix3_rgb", rgb, 1);
    goto(7); check("pix4_rgb", rgb, 2);

    goto(799); check("col798_addr", rd_addr_x, FB_W - 1);
    goto(800); check("col799_addr", rd_addr_x, FB_W - 1);
    check("col799_rd_en", rd_en, 1);
    goto(801);
    check("hblank_rd_en", rd_en, 0);
    check("hblank_addr_hold", rd_addr_x, FB_W - 1);
    check("we_low_after_last_rd", write_enable, 0);
    goto(802);
    check("col799_rgb", rgb, 15);
    check("we_rise", write_enable, 1);
    goto(803); check("col800_rgb", rgb, 0);

    goto(842); check("hsync_pre", hsync, 0);
    goto(843); check("hsync_rise", hsync, 1);
    goto(970); check("hsync_last", hsync, 1);
    goto(971); check("hsync_fall", hsync, 0);

    goto(LINE);     check("we_before_line1", write_enable, 1);
    goto(LINE + 1);
    check("we_fall_line1", write_enable, 0);
    check("line1_rd_en", rd_en, 1);
    check("line1_addr_y", rd_addr_y, 0);
    goto(LINE + 7); check("line1_pix4_rgb", rgb, 2);

    nz = 0;
    goto(LINE + 803);
    while (cyc <= LINE + 1058) begin
      if (rgb != 0) nz++;
      tick();
    end
    check("hblank_rgb_zero_256", nz, 0);

    goto(3 * LINE + 1); check("line3_addr_y", rd_addr_y, 1);
    goto(7 * LINE + 1); check("last_line_addr_y", rd_addr_y, (VVIS - 1) / 2);

    goto(VPS_C - 1); check("vps_pre", vertical_porch_start, 0);
    goto(VPS_C);     check("vps_pulse", vertical_porch_start, 1);

    we_low = 0; rd_hi = 0; vps_n = 0;
    while (cyc < VPS_C + FRAME) begin
      if (cyc < VPS_C + (16 - VVIS) * LINE) begin
        if (!write_enable) we_low++;
        if (rd_en) rd_hi++;
      end
      if (vertical_porch_start) vps_n++;
      if (cyc == 9 * LINE + 2)  check("vsync_pre", vsync, 0);
      if (cyc == 9 * LINE + 3)  check("vsync_rise", vsync, 1);
      if (cyc == 13 * LINE + 2) check("vsync_last", vsync, 1);
      if (cyc == 13 * LINE + 3) check("vsync_fall", vsync, 0);
      tick();
    end
    check("vblank_we_low_cycles", we_low, 0);
    check("vblank_rd_cycles", rd_hi, 0);
    check("vps_per_frame", vps_n, 1);
    check("vps_next_frame", vertical_porch_start, 1);
    goto(FRAME + 1);

    goto(2 * FRAME + 3 * LINE + 100);
    check("pre_reset_pixel", rgb, 48);
    rst = 1'b1;
    tick();
    check("midreset_outputs",
          32'({rd_en, rgb, hsync, vsync, write_enable, vertical_porch_start, rd_addr_x, rd_addr_y}), 0);
    rst = 1'b0;
    cyc = 0;
    goto(1);
    check("restart_rd_en", rd_en, 1);
    check("restart_addr", {rd_addr_x, rd_addr_y}, 0);
    vps_n = 0;
    while (cyc < VPS_C) begin
      if (vertical_porch_start) vps_n++;
      tick();
    end
    check("restart_no_early_vps", vps_n, 0);
    check("restart_vps", vertical_porch_start, 1);
    check("we_rd_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
